// File: rtl/ioblock_bank_if.sv
// ioblock_bank_if: serial configuration port of an I/O bank.
//   CFG_START  request to begin a configuration frame (one cycle)
//   CFG_VALID  qualifies CFG_DIN while a frame is loading
//   CFG_DIN    serial configuration bit
//   CFG_BUSY   frame loading or committing
//   CFG_DONE   one-cycle pulse: new configuration in effect
// master: the fabric-side configuration source; slave: the I/O bank.
interface ioblock_bank_if;
  logic CFG_START;
  logic CFG_VALID;
  logic CFG_DIN;
  logic CFG_BUSY;
  logic CFG_DONE;

  modport master (
    output CFG_START, CFG_VALID, CFG_DIN,
    input  CFG_BUSY, CFG_DONE
  );

  modport slave (
    input  CFG_START, CFG_VALID, CFG_DIN,
    output CFG_BUSY, CFG_DONE
  );
endinterface

// File: rtl/ioblock_bank.sv
// ioblock_bank: bank of NPINS configurable I/O cells at the fabric boundary.
// Each cell: tristate mode (TSMUX), optional registered output path (OREG),
// optional registered input path (IREG). Configuration is shifted serially
// into a shadow register and committed to the active register in one edge,
// so the pins keep running on the old configuration while a frame loads.
// Ports:
//   IOCLK  bank clock, rising edge
//   RST    asynchronous active-high reset
//   PIN    package pins (inout)
//   TS     per-pin output enable from fabric (1 = drive)
//   OUT    per-pin output data from fabric
//   IN     per-pin input data to fabric
//   cfg    serial configuration port (ioblock_bank_if.slave)
// Frame bit layout for pin p: 4p = TSMUX[0], 4p+1 = TSMUX[1], 4p+2 = IREG,
// 4p+3 = OREG.
module ioblock_bank #(
  parameter int NPINS = 4,
  parameter int CFGW  = 4
) (
  input  logic             IOCLK,
  input  logic             RST,
  inout  wire  [NPINS-1:0] PIN,
  input  logic [NPINS-1:0] TS,
  input  logic [NPINS-1:0] OUT,
  output logic [NPINS-1:0] IN,
  ioblock_bank_if.slave    cfg
);

  localparam int NBITS = CFGW * NPINS;
  localparam int CNTW  = $clog2(NBITS + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NBITS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] active;
  logic [NPINS-1:0] oq, tq, dq;
  logic             busy_q, done_q;
  logic [NPINS-1:0] drv_en, drv_d;

  // Configuration loader
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // CFG_VALID alongside an accepted start is deliberately dropped
          if (cfg.CFG_START) begin
            state  <= ST_SHIFT;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cfg.CFG_VALID) begin
            for (int unsigned i = 0; i < NBITS; i++) begin
              if (cnt == CNTW'(i)) shadow[i] <= cfg.CFG_DIN;
            end
            cnt <= cnt + CNTW'(1);
            if (cnt == LAST) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          active <= shadow;
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-pin I/O registers, free-running on every edge
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      oq <= '0;
      tq <= '0;
      dq <= '0;
    end else begin
      oq <= OUT;
      tq <= TS;
      dq <= PIN;
    end
  end

  // Per-pin output selection, tristate decode and input selection
  always_comb begin
    logic [1:0] tsmux;
    logic       sel_d;
    logic       sel_t;
    tsmux  = '0;
    sel_d  = 1'b0;
    sel_t  = 1'b0;
    drv_en = '0;
    drv_d  = '0;
    IN     = '0;
    for (int unsigned p = 0; p < NPINS; p++) begin
      tsmux = active[CFGW*p +: 2];
      sel_d = active[CFGW*p + 3] ? oq[p] : OUT[p];
      sel_t = active[CFGW*p + 3] ? tq[p] : TS[p];
      case (tsmux)
        2'b00:   drv_en[p] = 1'b0;
        2'b01:   drv_en[p] = sel_t;
        default: drv_en[p] = 1'b1;
      endcase
      drv_d[p] = sel_d;
      IN[p]    = active[CFGW*p + 2] ? dq[p] : PIN[p];
    end
  end

  for (genvar p = 0; p < NPINS; p++) begin : g_pad
    assign PIN[p] = drv_en[p] ? drv_d[p] : 1'bz;
  end

  assign cfg.CFG_BUSY = busy_q;
  assign cfg.CFG_DONE = done_q;

endmodule

// File: tb/tb_ioblock_bank.sv
module tb_ioblock_bank;

  localparam int S_IN4   = 0;
  localparam int S_PIN4  = 1;
  localparam int S_BUSY4 = 2;
  localparam int S_DONE4 = 3;
  localparam int S_PIN1  = 4;
  localparam int S_BUSY1 = 5;
  localparam int S_DONE1 = 6;

  typedef struct {
    string      name;
    int         sel;
    logic [3:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   finished = 1'b0;

  logic       IOCLK = 1'b0;
  logic       RST;
  logic [3:0] ts4, out4, ext_en, ext_val;
  logic [3:0] in4;
  wire  [3:0] pin4;
  logic [0:0] ts1, out1, in1;
  wire  [0:0] pin1;

  ioblock_bank_if c4();
  ioblock_bank_if c1();

  always #5 IOCLK = ~IOCLK;

  for (genvar i = 0; i < 4; i++) begin : g_ext
    assign pin4[i] = ext_en[i] ? ext_val[i] : 1'bz;
    pulldown (pin4[i]);
  end
  pulldown (pin1[0]);

  ioblock_bank #(.NPINS(4)) dut4 (
    .IOCLK(IOCLK), .RST(RST), .PIN(pin4), .TS(ts4), .OUT(out4), .IN(in4), .cfg(c4)
  );

  ioblock_bank #(.NPINS(1)) dut1 (
    .IOCLK(IOCLK), .RST(RST), .PIN(pin1), .TS(ts1), .OUT(out1), .IN(in1), .cfg(c1)
  );

  // Monitor: every falling edge, compare all expectations queued this cycle
  always @(negedge IOCLK) begin
    exp_t       e;
    logic [3:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        S_IN4:   obs = in4;
        S_PIN4:  obs = pin4;
        S_BUSY4: obs = {3'b0, c4.CFG_BUSY};
        S_DONE4: obs = {3'b0, c4.CFG_DONE};
        S_PIN1:  obs = {3'b0, pin1[0]};
        S_BUSY1: obs = {3'b0, c1.CFG_BUSY};
        default: obs = {3'b0, c1.CFG_DONE};
      endcase
      n_vec++;
      if (obs !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b want %b at %0t", e.name, obs, e.exp, $time);
      end
    end
  end

  initial begin
    #20000;
    if (!finished) begin
      n_bad++;
      $display("FAIL watchdog: test did not finish by %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $display("TEST FAILED");
      $finish;
    end
  end

  task automatic check_now(input string name, input logic [3:0] obs, input logic [3:0] v);
    n_vec++;
    if (obs !== v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, obs, v, $time);
    end
  endtask

  task automatic want(input string name, input int sel, input logic [3:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge IOCLK);
    #1;
  endtask

  // One frame on the 4-pin bank. Optional CFG_VALID on the start cycle,
  // optional gap (with a stray CFG_START) before every gap_every-th bit,
  // optional pin check: old_p during the load, new_p once CFG_DONE is up.
  task automatic frame4(input logic [15:0] f, input bit sv, input int gap_every,
                        input bit chk, input logic [3:0] old_p, input logic [3:0] new_p);
    tick();
    c4.CFG_START = 1'b1; c4.CFG_VALID = sv; c4.CFG_DIN = ~f[0];
    want("busy_start", S_BUSY4, 4'd0);
    tick();
    c4.CFG_START = 1'b0; c4.CFG_VALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) begin
        c4.CFG_VALID = 1'b0; c4.CFG_START = 1'b1; c4.CFG_DIN = ~f[i];
        want("busy_gap", S_BUSY4, 4'd1);
        if (chk) want("pin_hold_gap", S_PIN4, old_p);
        tick();
        c4.CFG_START = 1'b0;
      end
      c4.CFG_VALID = 1'b1; c4.CFG_DIN = f[i];
      if (i == 0 || i == 15) want("busy_shift", S_BUSY4, 4'd1);
      if (chk) want("pin_hold", S_PIN4, old_p);
      tick();
    end
    c4.CFG_VALID = 1'b0; c4.CFG_DIN = 1'b0;
    want("busy_commit", S_BUSY4, 4'd1);
    want("done_early", S_DONE4, 4'd0);
    if (chk) want("pin_commit", S_PIN4, old_p);
    tick();
    want("done_pulse", S_DONE4, 4'd1);
    want("busy_after", S_BUSY4, 4'd0);
    if (chk) want("pin_new", S_PIN4, new_p);
  endtask

  initial begin
    RST = 1'b1;
    ts4 = 4'hF; out4 = 4'hF; ext_en = 4'hF; ext_val = 4'b1010;
    ts1 = 1'b0; out1 = 1'b1;
    c4.CFG_START = 1'b0; c4.CFG_VALID = 1'b0; c4.CFG_DIN = 1'b0;
    c1.CFG_START = 1'b0; c1.CFG_VALID = 1'b0; c1.CFG_DIN = 1'b0;

    // Reset state: pins undriven, IN follows PIN
    tick();
    check_now("rst_in_now", in4, 4'b1010);
    check_now("rst_busy_now", {3'b0, c4.CFG_BUSY}, 4'd0);
    check_now("rst_done_now", {3'b0, c4.CFG_DONE}, 4'd0);
    want("rst_in", S_IN4, 4'b1010);
    want("rst_pin", S_PIN4, 4'b1010);
    want("rst_busy", S_BUSY4, 4'd0);
    want("rst_done", S_DONE4, 4'd0);
    tick();
    ext_en = 4'h0;
    want("rst_hiz", S_PIN4, 4'b0000);
    tick();
    RST = 1'b0;
    ts4 = 4'h0; out4 = 4'h0; ext_en = 4'b0100; ext_val = 4'h0;

    // pin0 TSMUX=01, pin1 TSMUX=10+OREG, pin2 IREG, pin3 off
    frame4(16'h04A1, 1'b0, 0, 1'b0, 4'h0, 4'h0);
    tick();
    out4 = 4'b1011; ts4 = 4'b1001; ext_val[2] = 1'b1;
    want("f1_pin_a", S_PIN4, 4'b0101);
    want("f1_in_a", S_IN4, 4'b0001);
    tick();
    out4 = 4'b1001; ts4 = 4'b1000; ext_val[2] = 1'b0;
    want("f1_pin_b", S_PIN4, 4'b0010);
    want("f1_in_b", S_IN4, 4'b0110);
    tick();
    want("f1_pin_c", S_PIN4, 4'b0000);
    want("f1_in_c", S_IN4, 4'b0000);

    // Atomic update with gaps and stray starts: pin3 TSMUX=10 only
    tick();
    ext_en = 4'h0; out4 = 4'hF; ts4 = 4'b0001;
    frame4(16'h2000, 1'b0, 3, 1'b1, 4'b0011, 4'b1000);

    // Reset after 7 of 16 bits
    tick();
    c4.CFG_START = 1'b1;
    tick();
    c4.CFG_START = 1'b0;
    for (int i = 0; i < 7; i++) begin
      c4.CFG_VALID = 1'b1; c4.CFG_DIN = 1'b1;
      want("mid_pin_old", S_PIN4, 4'b1000);
      tick();
    end
    c4.CFG_VALID = 1'b0;
    RST = 1'b1;
    want("mid_rst_pin", S_PIN4, 4'b0000);
    want("mid_rst_busy", S_BUSY4, 4'd0);
    want("mid_rst_in", S_IN4, 4'b0000);
    tick();
    RST = 1'b0;

    // Full frame after reset, with CFG_VALID on the start cycle
    frame4(16'h04A1, 1'b1, 0, 1'b1, 4'b0000, 4'b0011);

    // Single-pin bank: 4-bit frame, CFG_DONE six cycles after start
    tick();
    c1.CFG_START = 1'b1;
    want("n1_busy0", S_BUSY1, 4'd0);
    tick();
    c1.CFG_START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c1.CFG_VALID = 1'b1; c1.CFG_DIN = (i == 1);
      want("n1_busy", S_BUSY1, 4'd1);
      tick();
    end
    c1.CFG_VALID = 1'b0; c1.CFG_DIN = 1'b0;
    want("n1_done_early", S_DONE1, 4'd0);
    want("n1_pin_old", S_PIN1, 4'd0);
    tick();
    want("n1_done", S_DONE1, 4'd1);
    want("n1_pin_new", S_PIN1, 4'd1);
    tick();
    want("n1_done_end", S_DONE1, 4'd0);

    @(negedge IOCLK);
    #1;
    finished = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) $display("TEST PASSED");
    else            $display("TEST FAILED");
    $finish;
  end

endmodule
